// File: rtl/ram_dp.sv
// ram_dp: simple-dual-port synchronous RAM, one byte-enabled write
// port and one read port with read enable and a one-cycle valid pulse.
//
// Optional feature macro: RAM_CLEAR_EN
//   defined   -> post-reset clear engine writes CLR_VAL to every word,
//                Busy is high while it runs and port accesses are ignored
//   undefined -> no clear engine, Busy tied low, contents start undefined
//
// Ports:
//   Clk    in   clock, rising edge
//   Rst    in   asynchronous active-high reset
//   We     in   per-byte write enables (DATA_W/8)
//   Waddr  in   write address
//   Din    in   write data
//   Re     in   read enable
//   Raddr  in   read address
//   Dout   out  read data
//   Rvalid out  one-cycle pulse, Dout carries a completed read
//   Busy   out  clear engine running
module ram_dp #(
    parameter int              DATA_W      = 16,
    parameter int              ADDR_W      = 12,
    parameter int              OUT_REG     = 0,
    parameter int              WRITE_FIRST = 1,
    parameter logic [DATA_W-1:0] CLR_VAL   = '0
) (
    input  logic                Clk,
    input  logic                Rst,
    input  logic [DATA_W/8-1:0] We,
    input  logic [ADDR_W-1:0]   Waddr,
    input  logic [DATA_W-1:0]   Din,
    input  logic                Re,
    input  logic [ADDR_W-1:0]   Raddr,
    output logic [DATA_W-1:0]   Dout,
    output logic                Rvalid,
    output logic                Busy
);

    localparam int NB    = DATA_W / 8;
    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] r_mem [DEPTH];

    logic              w_busy;
    logic              w_clr_we;
    logic [ADDR_W-1:0] w_clr_addr;

`ifdef RAM_CLEAR_EN
    typedef enum logic [1:0] {
        S_RESET,
        S_CLEAR,
        S_READY
    } state_t;

    state_t            r_state;
    logic [ADDR_W-1:0] r_cnt;
    logic              r_busy;

    // The first edge after reset release already writes address 0, so
    // address 2^ADDR_W-1 is written on edge 2^ADDR_W, which also drops Busy.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            r_state <= S_RESET;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
        end else begin
            case (r_state)
                S_RESET: begin
                    r_state <= S_CLEAR;
                    r_cnt   <= r_cnt + 1'b1;
                end
                S_CLEAR: begin
                    if (r_cnt == {ADDR_W{1'b1}}) begin
                        r_state <= S_READY;
                        r_busy  <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign w_clr_we   = (r_state != S_READY);
    assign w_clr_addr = r_cnt;
    assign w_busy     = r_busy;
`else
    assign w_clr_we   = 1'b0;
    assign w_clr_addr = '0;
    assign w_busy     = 1'b0;
`endif

    logic [NB-1:0]     w_we;
    logic              w_re;
    logic [DATA_W-1:0] w_rdata;

    assign w_we = We & {NB{~w_busy}};
    assign w_re = Re & ~w_busy;

    // Memory array has no reset so it maps onto block RAM.
    always_ff @(posedge Clk) begin
        if (w_clr_we) begin
            r_mem[w_clr_addr] <= CLR_VAL;
        end else begin
            for (int b = 0; b < NB; b++) begin
                if (w_we[b]) begin
                    r_mem[Waddr][8*b +: 8] <= Din[8*b +: 8];
                end
            end
        end
    end

    // Write-first bypass: enabled bytes of a same-address write win.
    always_comb begin
        w_rdata = r_mem[Raddr];
        if ((WRITE_FIRST != 0) && (Raddr == Waddr)) begin
            for (int b = 0; b < NB; b++) begin
                if (w_we[b]) begin
                    w_rdata[8*b +: 8] = Din[8*b +: 8];
                end
            end
        end
    end

    logic [DATA_W-1:0] r_dout1;
    logic              r_rv1;

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            r_dout1 <= '0;
            r_rv1   <= 1'b0;
        end else begin
            r_rv1 <= w_re;
            if (w_re) begin
                r_dout1 <= w_rdata;
            end
        end
    end

    generate
        if (OUT_REG != 0) begin : g_oreg
            logic [DATA_W-1:0] r_dout2;
            logic              r_rv2;

            always_ff @(posedge Clk or posedge Rst) begin
                if (Rst) begin
                    r_dout2 <= '0;
                    r_rv2   <= 1'b0;
                end else begin
                    r_dout2 <= r_dout1;
                    r_rv2   <= r_rv1;
                end
            end

            assign Dout   = r_dout2;
            assign Rvalid = r_rv2;
        end else begin : g_noreg
            assign Dout   = r_dout1;
            assign Rvalid = r_rv1;
        end
    endgenerate

    assign Busy = w_busy;

endmodule
